// File: rtl/imm_encoder_if.sv
// Valid/ready bundle between the constant generator, imm_encoder and the instruction-word assembler.
// master: encoder side (drives in_ready and the output beat); slave: the surrounding logic.
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [1:0]  in_max_sel;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_sel;
   logic        out_sign_ena;
   logic [19:0] out_imm_field;
   logic        out_hi;
   logic        out_last;
   logic        out_ovf;

   modport master (
      input  in_valid, in_value, in_max_sel, out_ready,
      output in_ready, out_valid, out_sel, out_sign_ena, out_imm_field, out_hi, out_last, out_ovf
   );

   modport slave (
      output in_valid, in_value, in_max_sel, out_ready,
      input  in_ready, out_valid, out_sel, out_sign_ena, out_imm_field, out_hi, out_last, out_ovf
   );
endinterface

// File: rtl/imm_encoder.sv
// Encodes 32-bit constants into the smallest EXTENSION immediate format, or a hi/lo beat pair.
// Optional round-trip self-check built when IMM_ENCODER_CHECK_EN is defined.
module imm_encoder #(
   parameter bit SPLIT_ENA = 1'b1,
   parameter bit IMM5_ENA  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   imm_encoder_if.master bus,
   output logic         chk_err
);

   typedef enum logic {IDLE, LO} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_out_valid, w_out_valid_nxt;
   logic [1:0]  r_sel, w_sel_nxt;
   logic        r_sign, w_sign_nxt;
   logic [19:0] r_field, w_field_nxt;
   logic        r_hi, w_hi_nxt;
   logic        r_last, w_last_nxt;
   logic        r_ovf, w_ovf_nxt;
   logic [11:0] r_lo, w_lo_nxt;

   logic [31:0] w_v;
   logic [1:0]  w_max;
   logic        w_u5, w_s5, w_u15, w_s15, w_u20, w_s20;
   logic        w_en5, w_en15, w_en20;
   logic [1:0]  w_enc_sel;
   logic        w_enc_sign, w_enc_hi, w_enc_last, w_enc_ovf;
   logic [19:0] w_enc_field;
   logic        w_in_ready, w_acc, w_take;

   assign w_v   = bus.in_value;
   assign w_max = (bus.in_max_sel == 2'd3) ? 2'd2 : bus.in_max_sel;

   // Non-negative values are caught by the unsigned test first, so signed tests only need the negative range.
   assign w_u5  = ~|w_v[31:5];
   assign w_s5  = &w_v[31:4];
   assign w_u15 = ~|w_v[31:15];
   assign w_s15 = &w_v[31:14];
   assign w_u20 = ~|w_v[31:20];
   assign w_s20 = &w_v[31:19];

   assign w_en5  = IMM5_ENA;
   assign w_en15 = (w_max != 2'd0);
   assign w_en20 = (w_max == 2'd2);

   always_comb begin
      w_enc_sel   = 2'd2;
      w_enc_sign  = 1'b0;
      w_enc_field = w_v[19:0];
      w_enc_hi    = 1'b0;
      w_enc_last  = 1'b1;
      w_enc_ovf   = 1'b0;
      if (w_en5 && (w_u5 || w_s5)) begin
         w_enc_sel   = 2'd0;
         w_enc_sign  = !w_u5;
         w_enc_field = {5'b0, w_v[4:0], 10'b0};
      end else if (w_en15 && (w_u15 || w_s15)) begin
         w_enc_sel   = 2'd1;
         w_enc_sign  = !w_u15;
         w_enc_field = {5'b0, w_v[14:0]};
      end else if (w_en20 && (w_u20 || w_s20)) begin
         w_enc_sign  = !w_u20;
      end else if (SPLIT_ENA) begin
         w_enc_field = w_v[31:12];
         w_enc_hi    = 1'b1;
         w_enc_last  = 1'b0;
      end else begin
         w_enc_ovf   = 1'b1;
      end
   end

   assign w_in_ready = !r_out_valid || (bus.out_ready && r_last && (r_state == IDLE));
   assign w_acc      = bus.in_valid && w_in_ready;
   assign w_take     = r_out_valid && bus.out_ready;

   always_comb begin
      w_state_nxt     = r_state;
      w_out_valid_nxt = r_out_valid;
      w_sel_nxt       = r_sel;
      w_sign_nxt      = r_sign;
      w_field_nxt     = r_field;
      w_hi_nxt        = r_hi;
      w_last_nxt      = r_last;
      w_ovf_nxt       = r_ovf;
      w_lo_nxt        = r_lo;
      if (w_acc) begin
         w_state_nxt     = IDLE;
         w_out_valid_nxt = 1'b1;
         w_sel_nxt       = w_enc_sel;
         w_sign_nxt      = w_enc_sign;
         w_field_nxt     = w_enc_field;
         w_hi_nxt        = w_enc_hi;
         w_last_nxt      = w_enc_last;
         w_ovf_nxt       = w_enc_ovf;
         w_lo_nxt        = w_v[11:0];
      end else if (w_take) begin
         if (r_hi) begin
            w_state_nxt = LO;
            w_sel_nxt   = 2'd1;
            w_sign_nxt  = 1'b0;
            w_field_nxt = {8'b0, r_lo};
            w_hi_nxt    = 1'b0;
            w_last_nxt  = 1'b1;
            w_ovf_nxt   = 1'b0;
         end else begin
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_sel       <= '0;
         r_sign      <= 1'b0;
         r_field     <= '0;
         r_hi        <= 1'b0;
         r_last      <= 1'b0;
         r_ovf       <= 1'b0;
         r_lo        <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_sel       <= w_sel_nxt;
         r_sign      <= w_sign_nxt;
         r_field     <= w_field_nxt;
         r_hi        <= w_hi_nxt;
         r_last      <= w_last_nxt;
         r_ovf       <= w_ovf_nxt;
         r_lo        <= w_lo_nxt;
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_sel       = r_sel;
   assign bus.out_sign_ena  = r_sign;
   assign bus.out_imm_field = r_field;
   assign bus.out_hi        = r_hi;
   assign bus.out_last      = r_last;
   assign bus.out_ovf       = r_ovf;

`ifdef IMM_ENCODER_CHECK_EN
   logic [31:0] r_val, r_acc;
   logic        r_pend, r_chk_err;
   logic [31:0] w_ext, w_rebuilt;

   function automatic logic [31:0] ext(input logic sign, input logic [1:0] sel, input logic [19:0] f);
      case (sel)
         2'd0:    ext = sign ? {{27{f[14]}}, f[14:10]} : {27'b0, f[14:10]};
         2'd1:    ext = sign ? {{17{f[14]}}, f[14:0]}  : {17'b0, f[14:0]};
         default: ext = sign ? {{12{f[19]}}, f}        : {12'b0, f};
      endcase
   endfunction

   assign w_ext     = ext(r_sign, r_sel, r_field);
   assign w_rebuilt = r_pend ? (r_acc | w_ext) : w_ext;

   // Truncated overflow beats are already flagged by out_ovf, so they are excluded from the compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_val     <= '0;
         r_acc     <= '0;
         r_pend    <= 1'b0;
         r_chk_err <= 1'b0;
      end else begin
         if (w_acc) r_val <= w_v;
         if (w_take) begin
            if (r_hi) begin
               r_acc  <= w_ext << 12;
               r_pend <= 1'b1;
            end else if (r_last) begin
               r_pend <= 1'b0;
               if (!r_ovf && (w_rebuilt != r_val)) r_chk_err <= 1'b1;
            end
         end
      end
   end

   assign chk_err = r_chk_err;
`else
   assign chk_err = 1'b0;
`endif

endmodule
